// File: rtl/layer_scheduler.sv
// Layer scheduler: walks one shared inner-product datapath across every
// neuron of a layer, applies ReLU, writes results and tracks the argmax.
module layer_scheduler #(
    parameter int unsigned N_NEURON = 8,
    parameter int unsigned W        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          ready,
    input  logic          ip_ready,
    output logic          ip_start,
    input  logic [W-1:0]  acc_in,
    output logic [31:0]   neuron_sel,
    output logic          out_wr,
    output logic [W-1:0]  out_data,
    output logic [31:0]   max_idx,
    output logic [W-1:0]  max_val,
    output logic          done,
    output logic          err
);

    localparam int unsigned LAST_NEURON = N_NEURON - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_CALC,
        S_ACT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;
    logic   busy_seen;
    logic   busy_fault;
    logic   last_neuron;

    assign last_neuron = (neuron_sel == 32'(LAST_NEURON));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a second WAIT_BUSY cycle with ip_ready high is a fault.
    always_comb begin
        state_next = state;
        busy_fault = 1'b0;
        case (state)
            S_IDLE:      if (start) state_next = S_INIT;
            S_INIT:      state_next = S_LAUNCH;
            S_LAUNCH:    state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!ip_ready) begin
                    state_next = S_WAIT_CALC;
                end else if (busy_seen) begin
                    state_next = S_IDLE;
                    busy_fault = 1'b1;
                end
            end
            S_WAIT_CALC: if (ip_ready) state_next = S_ACT;
            S_ACT:       state_next = S_WRITE;
            S_WRITE:     state_next = last_neuron ? S_DONE : S_LAUNCH;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Marks that one WAIT_BUSY cycle has already elapsed with ip_ready high.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_seen <= 1'b0;
        end else begin
            busy_seen <= (state == S_WAIT_BUSY) && (state_next == S_WAIT_BUSY);
        end
    end

    // Moore strobes, registered from the next state so they track the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready    <= 1'b1;
            ip_start <= 1'b0;
            out_wr   <= 1'b0;
            done     <= 1'b0;
        end else begin
            ready    <= (state_next == S_IDLE);
            ip_start <= (state_next == S_LAUNCH);
            out_wr   <= (state_next == S_WRITE);
            done     <= (state_next == S_DONE);
        end
    end

    // Neuron index, ReLU result, running argmax and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            neuron_sel <= 32'd0;
            out_data   <= '0;
            max_idx    <= 32'd0;
            max_val    <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    neuron_sel <= 32'd0;
                    max_idx    <= 32'd0;
                    max_val    <= '0;
                    err        <= 1'b0;
                end
                S_ACT: begin
                    out_data <= acc_in[W-1] ? '0 : acc_in;
                end
                S_WRITE: begin
                    if ($signed(out_data) > $signed(max_val)) begin
                        max_val <= out_data;
                        max_idx <= neuron_sel;
                    end
                    if (!last_neuron) begin
                        neuron_sel <= neuron_sel + 32'd1;
                    end
                end
                default: begin
                end
            endcase
            if (busy_fault) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/layer_scheduler.md
Name: layer_scheduler

Overview:
- Sequences one shared inner-product neuron datapath (Ip controller, counter and accumulator) across N_NEURON neurons of a layer.
- Per neuron: selects the weight bank, launches the Ip controller over its start/ready handshake, and waits for completion.
- Then applies ReLU to the accumulator, writes the result to the layer output buffer, and tracks the running argmax.
- Sits between the top-level network FSM (start/ready) and the Ip controller (ip_start/ip_ready).

Parameters:
- N_NEURON, 8, number of neurons in the layer; must be >= 1.
- W, 16, accumulator/activation width, two's complement.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin layer; sampled only in IDLE.
- ready  out  1  high only in IDLE.
- ip_ready  in  1  ready from the Ip controller.
- ip_start  out  1  one-cycle launch pulse to the Ip controller.
- acc_in  in  W  signed accumulator output of the Ip datapath.
- neuron_sel  out  32  current neuron index; drives weight-bank select and output buffer address.
- out_wr  out  1  output buffer write strobe.
- out_data  out  W  ReLU result (registered).
- max_idx  out  32  index of the largest activation written so far.
- max_val  out  W  value at max_idx.
- done  out  1  one-cycle pulse at layer completion.
- err  out  1  sticky handshake error flag.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock is clk, reset is rst.
- Reset values: state IDLE, ready=1, ip_start=0, out_wr=0, done=0, neuron_sel=0, out_data=0, max_idx=0, max_val=0, err=0.
- Reset mid-layer returns to IDLE on the next edge. No partial write follows.
- States and transitions:
  - IDLE: ready=1. start=1 -> INIT.
  - INIT: clear neuron_sel, max_idx, max_val and err -> LAUNCH.
  - LAUNCH: ip_start=1 for exactly this cycle -> WAIT_BUSY.
  - WAIT_BUSY: waits for ip_ready=0.
    - ip_ready=0 -> WAIT_CALC.
    - ip_ready still 1 on the 2nd consecutive WAIT_BUSY cycle -> set err, go to IDLE.
  - WAIT_CALC: ip_ready=1 -> ACT.
  - ACT: out_data <= (acc_in[W-1]) ? 0 : acc_in -> WRITE.
  - WRITE: out_wr=1 with out_data and address neuron_sel.
    - If out_data > max_val (strict, signed): max_val <= out_data, max_idx <= neuron_sel. Ties keep the lower index.
    - neuron_sel==N_NEURON-1 -> DONE. Otherwise neuron_sel+1 -> LAUNCH.
  - DONE: done=1 for one cycle -> IDLE. neuron_sel, max_idx, max_val and out_data hold until the next INIT.
- start while not in IDLE is ignored.
- Outputs ready, ip_start, out_wr and done are decoded from state only (Moore).
- neuron_sel is stable from LAUNCH through WRITE of each neuron. It never wraps past N_NEURON-1.
- Latency:
  - Let B = number of cycles the Ip controller holds ip_ready low.
  - LAUNCH to next LAUNCH = B+4 cycles.
  - start to done = 1 + N_NEURON*(B+4) cycles, counting INIT through DONE.
- err stays set until the next INIT or rst. max_idx/max_val keep values from neurons completed before the error.

Test Plan:
- Basic layer, N_NEURON=4, Ip model with B=12, acc_in per neuron 5, -3, 20, 7:
  - out_wr pulses 4 times, addr 0..3, data 5, 0, 20, 7.
  - max_idx=2, max_val=20.
  - done exactly 1+4*16=65 cycles after the start edge, then ready=1.
- Ties and negatives, acc_in 9, 9, -1, 9: max_idx=0, max_val=9. The negative entry is written as 0.
- Handshake fault: Ip model never drops ip_ready. Expect err=1, return to IDLE after 2 WAIT_BUSY cycles, no out_wr, no done. The next start clears err.
- start held high throughout the layer: exactly one ip_start per neuron. After DONE a new layer starts, since IDLE samples start=1.
- rst asserted during WAIT_CALC of neuron 2: next cycle all outputs hold their reset values and no further out_wr occurs. A fresh start then runs a full layer from neuron 0.
- N_NEURON=1, acc_in=-8: single write of 0, max_idx=0, max_val=0, done after 1+(B+4) cycles.
